// File: rtl/noc_mem_arbiter.sv
// Round-robin arbiter that shares one memory_interface port among N_REQ requesters.
// It keeps one transaction in flight, routes each response back by ID, and uses a watchdog to complete a stalled transaction with an error.
module noc_mem_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned ID_W    = $clog2(N_REQ),
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                      fclk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ-1:0]          req_we,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic [ADDR_W-1:0]         mem_req_addr,
  output logic                      mem_req_we,
  output logic [DATA_W-1:0]         mem_req_wdata,
  output logic [ID_W-1:0]           mem_req_id,
  input  logic                      mem_rsp_valid,
  input  logic [ID_W-1:0]           mem_rsp_id,
  input  logic [DATA_W-1:0]         mem_rsp_data,
  output logic                      busy,
  output logic [7:0]                stray_cnt
);

  localparam int unsigned TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;
  logic [7:0]          stray_q, stray_d;

  logic                grant_found;
  logic [ID_W-1:0]     grant_idx;
  logic                rsp_match;

  // Scan starts at rr_ptr and wraps, so the most recent winner becomes the lowest priority.
  always_comb begin : arb_scan
    logic [ID_W-1:0] cand;
    cand        = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = ID_W'((32'(rr_ptr_q) + k) % N_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign rsp_match = mem_rsp_valid && (mem_rsp_id == owner_q);

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    timer_d    = timer_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    stray_d    = stray_q;

    unique case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          addr_d   = req_addr[32'(grant_idx) * ADDR_W +: ADDR_W];
          we_d     = req_we[grant_idx];
          wdata_d  = req_wdata[32'(grant_idx) * DATA_W +: DATA_W];
          owner_d  = grant_idx;
          rr_ptr_d = ID_W'((32'(grant_idx) + 1) % N_REQ);
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (mem_req_ready) begin
          timer_d = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // A matching response arriving on the final watchdog cycle still completes without error.
        if (rsp_match) begin
          rsp_data_d = we_q ? '0 : mem_rsp_data;
          rsp_err_d  = 1'b0;
          state_d    = S_RESP;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = S_RESP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (mem_rsp_valid && !(state_q == S_WAIT && rsp_match) && (stray_q != 8'hFF)) begin
      stray_d = stray_q + 8'd1;
    end
  end

  always_ff @(posedge fclk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      timer_q    <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      stray_q    <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      timer_q    <= timer_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      stray_q    <= stray_d;
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == S_IDLE && grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
    rsp_valid = '0;
    if (state_q == S_RESP) begin
      rsp_valid[owner_q] = 1'b1;
    end
  end

  assign mem_req_valid = (state_q == S_ISSUE);
  assign mem_req_addr  = addr_q;
  assign mem_req_we    = we_q;
  assign mem_req_wdata = wdata_q;
  assign mem_req_id    = owner_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_err       = rsp_err_q;
  assign busy          = (state_q != S_IDLE);
  assign stray_cnt     = stray_q;

endmodule
